// File: rtl/cmd_issuer.sv
// Serial command issuer: sends a command byte plus little-endian argument bytes, then collects a binary or text reply.
// Optional reply timeout is built in when CMD_TIMEOUT_EN is defined.
module cmd_issuer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_arg,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        txt_valid,
    output logic [7:0]  txt_data,
    output logic        busy
);

    // state    | meaning
    // IDLE     | ready for a request
    // SEND_CMD | command byte offered on tx
    // SEND_ARG | argument bytes offered on tx, LSB first
    // WAIT_RSP | collecting rx reply bytes
    // DONE     | one-cycle completion with rsp_valid
    typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_ARG, WAIT_RSP, DONE} state_t;
    typedef enum logic [1:0] {RSP_NONE, RSP_BIN1, RSP_BIN2, RSP_TEXT} rsp_class_t;

    state_t      state;
    logic [7:0]  cmd_q;
    logic [31:0] arg_q;
    logic [2:0]  arg_left;
    logic        lo_seen;
    logic [7:0]  lo_byte;

    function automatic logic [2:0] arg_bytes(input logic [7:0] c);
        case (c)
            "A":           return 3'd2;
            "B":           return 3'd1;
            "O", "M", "r": return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic rsp_class_t rsp_class(input logic [7:0] c);
        case (c)
            "a":           return RSP_BIN2;
            "b", "s", "r": return RSP_BIN1;
            "I", "R":      return RSP_TEXT;
            default:       return RSP_NONE;
        endcase
    endfunction

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            txt_valid <= 1'b0;
            txt_data  <= '0;
            cmd_q     <= '0;
            arg_q     <= '0;
            arg_left  <= '0;
            lo_seen   <= 1'b0;
            lo_byte   <= '0;
`ifdef CMD_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            txt_valid <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_q    <= req_cmd;
                        arg_q    <= req_arg;
                        arg_left <= arg_bytes(req_cmd);
                        tx_valid <= 1'b1;
                        tx_data  <= req_cmd;
                        state    <= SEND_CMD;
                    end
                end
                // arg_left counts argument bytes not yet placed on tx_data
                SEND_CMD, SEND_ARG: begin
                    if (tx_ready) begin
                        if (arg_left == 3'd0) begin
                            tx_valid <= 1'b0;
                            if (rsp_class(cmd_q) == RSP_NONE) begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= '0;
                            end else begin
                                state   <= WAIT_RSP;
                                lo_seen <= 1'b0;
`ifdef CMD_TIMEOUT_EN
                                tmo_cnt <= TMO_LOAD;
`endif
                            end
                        end else begin
                            tx_data  <= arg_q[7:0];
                            arg_q    <= arg_q >> 8;
                            arg_left <= arg_left - 3'd1;
                            state    <= SEND_ARG;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rx_valid && rx_data != 8'hFF) begin
`ifdef CMD_TIMEOUT_EN
                        tmo_cnt <= TMO_LOAD;
`endif
                        case (rsp_class(cmd_q))
                            RSP_BIN1: begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= {24'd0, rx_data};
                            end
                            RSP_BIN2: begin
                                if (lo_seen) begin
                                    state     <= DONE;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= {16'd0, rx_data, lo_byte};
                                end else begin
                                    lo_byte <= rx_data;
                                    lo_seen <= 1'b1;
                                end
                            end
                            RSP_TEXT: begin
                                if (rx_data == 8'h0A) begin
                                    state     <= DONE;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    txt_valid <= 1'b1;
                                    txt_data  <= rx_data;
                                end
                            end
                            default: state <= DONE;
                        endcase
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: vector table plus hand sequences, scoreboard queues for tx, text and response outputs.
module tb_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = '0;
    logic [31:0] req_arg = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        txt_valid;
    logic [7:0]  txt_data;
    logic        busy;

    cmd_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_arg(req_arg),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .txt_valid(txt_valid), .txt_data(txt_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_txt[$];
    logic [32:0] exp_rsp[$];
    int          tx_cyc[$];
    logic        stall_pending = 1'b0;
    logic [7:0]  stall_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_pending <= 1'b0;
        end else begin
            if (stall_pending && tx_valid) chk("tx_stable", tx_data, stall_data);
            stall_pending <= tx_valid && !tx_ready;
            stall_data    <= tx_data;
            if (tx_valid && tx_ready) begin
                tx_cyc.push_back(cyc);
                if (exp_tx.size() == 0) flag("tx_unexpected");
                else chk("tx_byte", tx_data, exp_tx.pop_front());
            end
            if (txt_valid) begin
                if (exp_txt.size() == 0) flag("txt_unexpected");
                else chk("txt_byte", txt_data, exp_txt.pop_front());
            end
            if (rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) flag("rsp_unexpected");
                else chk("rsp", {rsp_timeout, rsp_data}, exp_rsp.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] c, input logic [31:0] a);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) flag("req_ready_wait");
        req_valid = 1'b1;
        req_cmd   = c;
        req_arg   = a;
        tick();
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic wait_tx_empty(input int lim);
        int n = 0;
        while (exp_tx.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        if (exp_tx.size() != 0) begin
            flag("tx_wait_expired");
            exp_tx.delete();
        end
    endtask

    task automatic wait_rsp(input int lim);
        int n = 0;
        while (exp_rsp.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        if (exp_rsp.size() != 0) begin
            flag("rsp_wait_expired");
            exp_rsp.delete();
        end
        tick();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic txt);
        rx_valid = 1'b1;
        rx_data  = b;
        if (txt && b != 8'h0A && b != 8'hFF) exp_txt.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] arg;
        int          n_arg;
        logic        no_rsp;
        logic        is_txt;
        int          n_rx;
        logic [47:0] rx;     // first rx byte in bits [7:0]
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"A", 32'h0000BEEF, 2, 1'b1, 1'b0, 0, 48'h0,          32'h0};
        vecs[1]  = '{"B", 32'h12345678, 1, 1'b1, 1'b0, 0, 48'h0,          32'h0};
        vecs[2]  = '{"a", 32'h0000FFFF, 0, 1'b0, 1'b0, 2, 48'h1234,       32'h1234};
        vecs[3]  = '{"b", 32'h0,        0, 1'b0, 1'b0, 2, 48'h7EFF,       32'h7E};
        vecs[4]  = '{"r", 32'hDEADBEEF, 4, 1'b0, 1'b0, 1, 48'h5A,         32'h5A};
        vecs[5]  = '{"R", 32'h0,        0, 1'b0, 1'b1, 5, 48'h0A4B524223, 32'h0};
        vecs[6]  = '{"I", 32'h0,        0, 1'b0, 1'b1, 4, 48'h0A69FF68,   32'h0};
        vecs[7]  = '{"Z", 32'h0000CAFE, 0, 1'b1, 1'b0, 0, 48'h0,          32'h0};
        vecs[8]  = '{"O", 32'h01020304, 4, 1'b1, 1'b0, 0, 48'h0,          32'h0};
        vecs[9]  = '{"s", 32'h0,        0, 1'b0, 1'b0, 1, 48'h80,         32'h80};
        vecs[10] = '{"a", 32'h0,        0, 1'b0, 1'b0, 4, 48'h80FF01FF,   32'h8001};

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_txt_valid", txt_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_txt_data", txt_data, 0);

        for (int v = 0; v < 11; v++) begin
            logic [31:0] a;
            tx_cyc.delete();
            tx_ready = 1'b1;
            a = vecs[v].arg;
            exp_tx.push_back(vecs[v].cmd);
            for (int i = 0; i < vecs[v].n_arg; i++) exp_tx.push_back(a[8*i +: 8]);
            exp_rsp.push_back({1'b0, vecs[v].exp});
            issue(vecs[v].cmd, vecs[v].arg);
            wait_tx_empty(20);
            for (int i = 0; i < vecs[v].n_rx; i++) send_rx(vecs[v].rx[8*i +: 8], vecs[v].is_txt);
            wait_rsp(20);
            if (tx_cyc.size() > 0) begin
                chk("first_tx_cycle", tx_cyc[0], acc_cyc);
                chk("tx_back_to_back", tx_cyc[$] - tx_cyc[0], vecs[v].n_arg);
                if (vecs[v].no_rsp) chk("rsp_latency", rsp_cyc, tx_cyc[$] + 1);
            end
            chk("idle_req_ready", req_ready, 1);
            chk("idle_busy", busy, 0);
            chk("rsp_data_hold", rsp_data, vecs[v].exp);
        end

        // rx during SEND_CMD and on the last tx transfer cycle must be dropped
        tx_ready = 1'b0;
        exp_tx.push_back("a");
        exp_rsp.push_back({1'b0, 32'h1234});
        issue("a", 32'h0);
        rx_valid = 1'b1; rx_data = 8'h55;
        tick();
        rx_valid = 1'b0;
        tick();
        tx_ready = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h66;
        tick();
        rx_valid = 1'b0;
        send_rx(8'h34, 1'b0);
        send_rx(8'h12, 1'b0);
        wait_rsp(20);

        // 'M' with tx_ready toggling every cycle
        tx_ready = 1'b0;
        exp_tx.push_back(8'h4D);
        exp_tx.push_back(8'h44);
        exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h11);
        exp_rsp.push_back({1'b0, 32'h0});
        issue("M", 32'h11223344);
        for (int n = 0; n < 30 && exp_tx.size() != 0; n++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        if (exp_tx.size() != 0) begin
            flag("m_tx_expired");
            exp_tx.delete();
        end
        tx_ready = 1'b1;
        wait_rsp(20);

        // reset during the second argument byte of 'O'
        exp_tx.push_back(8'h4F);
        exp_tx.push_back(8'hDD);
        issue("O", 32'hAABBCCDD);
        wait_tx_empty(20);
        chk("o_second_byte", tx_data, 8'hCC);
        tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        tx_ready = 1'b1;
        exp_tx.push_back(8'h4E);
        exp_rsp.push_back({1'b0, 32'h0});
        issue("N", 32'h99887766);
        wait_rsp(20);
        repeat (5) tick();

`ifdef CMD_TIMEOUT_EN
        // timeout after 16 WAIT_RSP cycles; filler does not extend it
        exp_tx.push_back("s");
        exp_rsp.push_back({1'b1, 32'h0});
        issue("s", 32'h0);
        repeat (5) tick();
        send_rx(8'hFF, 1'b0);
        wait_rsp(40);
        chk("timeout_cycle", rsp_cyc, acc_cyc + 17);

        // an accepted byte restarts the wait
        exp_tx.push_back("a");
        exp_rsp.push_back({1'b1, 32'h0});
        issue("a", 32'h0);
        repeat (3) tick();
        send_rx(8'h12, 1'b0);
        wait_rsp(40);
        chk("timeout_restart_cycle", rsp_cyc, acc_cyc + 20);
`else
        // without the timeout feature, WAIT_RSP waits indefinitely
        exp_tx.push_back("s");
        issue("s", 32'h0);
        wait_tx_empty(20);
        repeat (60) tick();
        chk("wait_forever_busy", busy, 1);
        exp_rsp.push_back({1'b0, 32'h3C});
        send_rx(8'h3C, 1'b0);
        wait_rsp(20);
`endif

        if (exp_txt.size() != 0) flag("txt_missing");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in WAIT_RSP without an rx byte (used only with CMD_TIMEOUT_EN).
REQ-002 Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  command request present.
- req_ready  out  1  high only in IDLE.
- req_cmd  in  8  ASCII command byte.
- req_arg  in  32  argument, sent little-endian.
- tx_valid  out  1  byte offered to serial link.
- tx_ready  in  1  link accepts byte.
- tx_data  out  8  outgoing byte.
- rx_valid  in  1  one-cycle strobe, received byte; no backpressure.
- rx_data  in  8  received byte.
- rsp_valid  out  1  one-cycle pulse, command complete.
- rsp_data  out  32  binary reply, zero-extended.
- rsp_timeout  out  1  qualifies rsp_valid; reply timed out.
- txt_valid  out  1  one-cycle pulse, text reply byte.
- txt_data  out  8  text reply byte.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, SEND_CMD, SEND_ARG, WAIT_RSP, DONE.
REQ-004 In IDLE, req_valid&&req_ready SHALL latch req_cmd/req_arg and enter SEND_CMD; tx_valid rises the next cycle with tx_data=req_cmd.
REQ-005 A tx byte SHALL transfer only on tx_valid&&tx_ready; tx_valid/tx_data SHALL hold stable until transfer.
REQ-006 Argument byte count: 'A'=2, 'B'=1, 'O'/'M'/'r'=4, all others (including unknown) =0; bytes sent LSB first in SEND_ARG, back-to-back when tx_ready stays high.
REQ-007 Reply class: 'a'=2 binary bytes, 'b'/'s'/'r'=1 binary byte, 'I'/'R'=text, all others=none.
REQ-008 After the last tx transfer, the FSM SHALL enter WAIT_RSP (binary/text) or DONE (none) on the next cycle.
REQ-009 rx bytes arriving outside WAIT_RSP, including on the cycle of the last tx transfer, SHALL be discarded.
REQ-010 Binary replies SHALL be assembled little-endian; after the final byte, enter DONE with rsp_data holding the zero-extended value.
REQ-011 Text replies: each rx byte other than 0x0A SHALL pulse txt_valid with txt_data on the following cycle; 0x0A SHALL not be forwarded and SHALL enter DONE.
REQ-012 DONE SHALL last one cycle with rsp_valid=1, then return to IDLE; rsp_data SHALL be 0 for none/text classes.
REQ-013 rsp_data SHALL hold its value until the next rsp_valid.
REQ-014 rx byte 0xFF in WAIT_RSP SHALL be treated as link filler and ignored (not assembled, not forwarded).

Reset
REQ-015 rst SHALL force IDLE on the next edge from any state, including mid-transfer; tx_valid, rsp_valid, rsp_timeout, txt_valid and busy SHALL be 0, rsp_data/txt_data SHALL be 0, and req_ready SHALL be 1.
REQ-016 A partially sent command SHALL not resume after reset.

Configuration
REQ-017 Macro CMD_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT_RSP and on every accepted rx byte; when it reaches TIMEOUT_CYCLES, the FSM SHALL enter DONE with rsp_timeout=1 and rsp_data=0.
REQ-018 CMD_TIMEOUT_EN undefined: no counter SHALL exist, rsp_timeout SHALL be tied to 0, and WAIT_RSP SHALL wait indefinitely.

Verification
REQ-019 Send 'A' with arg 0x0000BEEF and tx_ready=1 -> tx bytes 0x41,0xEF,0xBE over 3 consecutive cycles; rsp_valid 1 cycle later with rsp_data=0.
REQ-020 Send 'a', then rx 0x34,0x12 -> rsp_valid with rsp_data=0x00001234; an rx byte injected during SEND_CMD is ignored.
REQ-021 Send 'R', rx "#BRK" then 0x0A -> 4 txt_valid pulses 0x23,0x42,0x52,0x4B, then rsp_valid with rsp_data=0.
REQ-022 Send 'M' arg 0x11223344 with tx_ready toggling every cycle -> bytes 0x4D,0x44,0x33,0x22,0x11 in order; tx_data stable while stalled.
REQ-023 Assert rst during the second arg byte of 'O' -> tx_valid=0 and req_ready=1 the next cycle; the following 'N' request sends only 0x4E.
REQ-024 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, send 's' with no rx -> rsp_valid with rsp_timeout=1 exactly 16 cycles after entering WAIT_RSP; an rx of 0xFF does not extend the wait.
